dot16_seq_ctrl: RTL
===================

Name: dot16_seq_ctrl

Overview:
- Sequencer and accumulator for the dot16 ALM datapath.
- Accepts a job of LEN 16-element chunks and gates the datapath ena. Tracks in-flight chunks through the fixed-latency pipeline with a valid-tag shift register.
- Sums the per-chunk dot16 results into one wide signed result, presented on a valid/ready output.
- Operand buses route straight from the source to the datapath; this block carries only control and the datapath result.

Parameters:
- DATA_WIDTH, 8: operand width; datapath result is DATA_WIDTH*2+4 bits, signed.
- DP_LATENCY, 8: cycles from chunk accept to matching dp_res, with dp_ena held high.
- LEN_WIDTH, 8: width of the chunk count.
- ACC_WIDTH, DATA_WIDTH*2+4+LEN_WIDTH: accumulator and result width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  pulse: begin a job; sampled only in IDLE.
- len  in  LEN_WIDTH  number of chunks in the job; captured on start.
- in_valid  in  1  source presents a chunk on the datapath a/b inputs.
- in_ready  out  1  chunk accepted this cycle when in_valid&in_ready.
- dp_ena  out  1  datapath ena.
- dp_res  in  DATA_WIDTH*2+4  datapath res_out, signed.
- busy  out  1  state != IDLE.
- res_out  out  ACC_WIDTH  final signed dot product.
- res_valid  out  1  res_out valid.
- res_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (rst=0, async): state=IDLE; accumulator, remaining count and tag register cleared. in_ready, dp_ena, busy, res_valid all 0; res_out=0.
- IDLE:
  - start=1, len>0: capture len into remaining; clear accumulator and tags; go to RUN.
  - start=1, len=0: go directly to DONE with res_out=0.
- RUN:
  - in_ready=1; dp_ena=1 every cycle, including bubbles.
  - On accept: tag[0]=1 and remaining-1; otherwise tag[0]=0. The tag register shifts every dp_ena cycle.
  - Accepting the last chunk (remaining==1): go to DRAIN.
- DRAIN: in_ready=0, dp_ena=1. When the tag register is empty and the last tagged accumulate has completed, latch res_out and go to DONE.
- Accumulate: when tag[DP_LATENCY-1]=1, acc <= acc + sign_extend(dp_res, ACC_WIDTH). A chunk accepted in cycle t is added at the clock edge ending cycle t+DP_LATENCY.
- Latency: res_valid rises the cycle after the last accumulate, i.e. at accept_of_last + DP_LATENCY + 1.
- DONE:
  - res_valid=1; res_out held stable; dp_ena=0; in_ready=0.
  - res_valid&res_ready: go to IDLE with res_valid=0 next cycle.
- start outside IDLE is ignored, and the in-flight job is unaffected. start on the same cycle as the result handshake is also ignored; IDLE is required first.
- in_valid outside RUN is ignored.
- Overflow: not possible with full-length jobs, since ACC_WIDTH covers 2^LEN_WIDTH-1 chunks; arithmetic wraps two's-complement.
- Reset mid-job: everything clears immediately; partial results are discarded; the first post-reset job starts clean.

Optional Feature:
- Macro: DOT16_SEQ_PERF_EN.
- Defined:
  - Adds outputs perf_cycles (32 bits) and perf_bubbles (32 bits).
  - perf_cycles counts cycles with busy=1 for the current job; perf_bubbles counts RUN cycles without accept.
  - Both clear on job start, hold their value in DONE/IDLE, and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Bench datapath model: dp_res = sum of 16 products, delayed DP_LATENCY dp_ena cycles.
- len=1, all a=1, b=1, in_valid held high -> one accept; res_valid at accept+9 with res_out=16; held until res_ready.
- len=4, a_i=-1, b_i=3 every chunk -> res_out=-192, sign-extended to ACC_WIDTH.
- len=3, in_valid pattern 1,0,0,1,0,1 -> exactly 3 accepts; res_out = sum of the 3 chunk results; res_valid 9 cycles after the 3rd accept. With DOT16_SEQ_PERF_EN: perf_bubbles=3.
- len=0 start -> res_valid next cycle, res_out=0, no dp_ena pulses.
- start pulsed during RUN and in DONE, res_ready held low 5 cycles -> start ignored; res_out stable; new job accepted only after return to IDLE.
- rst asserted in DRAIN -> all outputs 0 immediately. Next len=2 job with dp_res 5 and 7 -> res_out=12, no residue from the aborted job.

Source files
------------

// File: rtl/dot16_seq_ctrl.sv
// Sequencer/accumulator for the dot16 datapath: gates dp_ena, tags in-flight chunks, sums results.
// Optional perf counters enabled with `define DOT16_SEQ_PERF_EN.
module dot16_seq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DP_LATENCY = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int ACC_WIDTH  = DATA_WIDTH*2+4+LEN_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [LEN_WIDTH-1:0]           len,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           dp_ena,
  input  logic signed [DATA_WIDTH*2+3:0] dp_res,
  output logic                           busy,
  output logic signed [ACC_WIDTH-1:0]    res_out,
  output logic                           res_valid,
  input  logic                           res_ready
`ifdef DOT16_SEQ_PERF_EN
  ,
  output logic [31:0]                    perf_cycles,
  output logic [31:0]                    perf_bubbles
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                      state_q, state_d;
  logic [LEN_WIDTH-1:0]        rem_q, rem_d;
  logic [DP_LATENCY-1:0]       tag_q, tag_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        accept;
  logic                        job_start;

  assign accept    = in_valid & in_ready;
  assign job_start = (state_q == IDLE) & start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // DRAIN exits on the edge that performs the final accumulate, so tag_d is tested
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = (len != '0) ? RUN : DONE;
      RUN:   if (accept && rem_q == LEN_WIDTH'(1)) state_d = DRAIN;
      DRAIN: if (tag_d == '0) state_d = DONE;
      DONE:  if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == RUN);
    dp_ena    = (state_q == RUN) || (state_q == DRAIN);
    busy      = (state_q != IDLE);
    res_valid = (state_q == DONE);
    res_out   = (state_q == DONE) ? acc_q : '0;
  end

  always_comb begin
    rem_d = rem_q;
    tag_d = tag_q;
    acc_d = acc_q;
    if (job_start) begin
      rem_d = len;
      tag_d = '0;
      acc_d = '0;
    end else if (dp_ena) begin
      tag_d = (tag_q << 1) | DP_LATENCY'(accept);
      if (accept) rem_d = rem_q - LEN_WIDTH'(1);
      if (tag_q[DP_LATENCY-1]) acc_d = acc_q + ACC_WIDTH'($signed(dp_res));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q <= '0;
      tag_q <= '0;
      acc_q <= '0;
    end else begin
      rem_q <= rem_d;
      tag_q <= tag_d;
      acc_q <= acc_d;
    end
  end

`ifdef DOT16_SEQ_PERF_EN
  // Counting stops in DONE so the values stay readable until the next start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles  <= '0;
      perf_bubbles <= '0;
    end else if (job_start) begin
      perf_cycles  <= '0;
      perf_bubbles <= '0;
    end else begin
      if (dp_ena) perf_cycles <= perf_cycles + 32'd1;
      if ((state_q == RUN) && !accept) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule
